// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator between the CPU execute stage and a
// word-addressed data memory. Sub-word stores use read-modify-write; loads
// do lane extraction and sign/zero extension. Misaligned, reserved-size and
// out-of-range accesses complete with err and never touch the memory.
module dmem_lsu #(
  parameter int unsigned DEPTH     = 2048,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        CS,
  output logic        DM_W,
  output logic        DM_R,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_FAULT
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_size;
  logic        r_sext;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata_lo;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic [31:0] w_off;
  logic        w_fault;
  logic        w_accept;
  logic        w_complete;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  // BASE_ADDR is word aligned, so off[1:0] equals addr[1:0] and is used as the lane.
  assign w_off      = addr - BASE_ADDR;
  assign w_accept   = (r_state == S_IDLE) && req;
  assign w_complete = (r_state == S_LOAD) || (r_state == S_STORE) ||
                      (r_state == S_RMW_WR) || (r_state == S_FAULT);

  // Classify the incoming request: reserved size, misalignment, out of range.
  always_comb begin
    w_fault = 1'b0;
    unique case (size)
      2'b11:   w_fault = 1'b1;
      2'b01:   if (w_off[0]) w_fault = 1'b1;
      2'b10:   if (w_off[1:0] != 2'b00) w_fault = 1'b1;
      default: w_fault = 1'b0;
    endcase
    if (addr < BASE_ADDR) w_fault = 1'b1;
    if ({2'b00, w_off[31:2]} >= 32'(DEPTH)) w_fault = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and Moore strobe decode.
  always_comb begin
    w_next = r_state;
    CS     = 1'b0;
    DM_W   = 1'b0;
    DM_R   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_fault)           w_next = S_FAULT;
          else if (!we)          w_next = S_LOAD;
          else if (size == 2'b10) w_next = S_STORE;
          else                   w_next = S_RMW_RD;
        end
      end
      S_LOAD: begin
        CS     = 1'b1;
        DM_R   = 1'b1;
        w_next = S_IDLE;
      end
      S_STORE: begin
        CS     = 1'b1;
        DM_W   = 1'b1;
        w_next = S_IDLE;
      end
      S_RMW_RD: begin
        CS     = 1'b1;
        DM_R   = 1'b1;
        w_next = S_RMW_WR;
      end
      S_RMW_WR: begin
        CS     = 1'b1;
        DM_W   = 1'b1;
        w_next = S_IDLE;
      end
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Load lane extraction/extension and RMW lane merge from the memory word.
  always_comb begin
    w_byte  = mem_rdata[{r_lane, 3'b000} +: 8];
    w_half  = mem_rdata[{r_lane[1], 4'b0000} +: 16];
    w_load  = mem_rdata;
    w_merge = mem_rdata;
    unique case (r_size)
      2'b00: begin
        w_load = {{24{r_sext & w_byte[7]}}, w_byte};
        w_merge[{r_lane, 3'b000} +: 8] = r_wdata_lo[7:0];
      end
      2'b01: begin
        w_load = {{16{r_sext & w_half[15]}}, w_half};
        w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata_lo;
      end
      default: begin
        w_load  = mem_rdata;
        w_merge = mem_rdata;
      end
    endcase
  end

  // Request latch, memory-side address/data, load result and completion flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_size      <= '0;
      r_sext      <= 1'b0;
      r_lane      <= '0;
      r_wdata_lo  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_done <= w_complete;
      r_err  <= (r_state == S_FAULT);
      if (w_accept) begin
        r_size      <= size;
        r_sext      <= sign_ext;
        r_lane      <= w_off[1:0];
        r_wdata_lo  <= wdata[15:0];
        r_mem_addr  <= {w_off[31:2], 2'b00};
        r_mem_wdata <= wdata;
      end
      if (r_state == S_LOAD) r_rdata <= w_load;
      // mem_wdata doubles as the merge register for the RMW write cycle.
      if (r_state == S_RMW_RD) r_mem_wdata <= w_merge;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed test-plan steps followed by
// randomized accesses checked against an operation-level reference model.
module tb_dmem_lsu;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] A10   = BASE + 32'h10;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        CS;
  logic        DM_W;
  logic        DM_R;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dmem_lsu #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .CS(CS), .DM_W(DM_W),
    .DM_R(DM_R), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed data memory attached to the DUT.
  logic [31:0] mem [DEPTH] = '{default: 32'h0};
  logic        mem_hit;
  assign mem_hit   = (mem_addr[31:AW+2] == '0);
  assign mem_rdata = (CS && DM_R && mem_hit) ? mem[mem_addr[AW+1:2]] : 32'h0;
  always @(posedge clk) if (CS && DM_W && mem_hit) mem[mem_addr[AW+1:2]] <= mem_wdata;

  // Strobe/busy cycle counters sampled mid-cycle.
  int unsigned cs_cnt = 0, dmw_cnt = 0, dmr_cnt = 0, busy_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  always @(negedge clk) begin
    if (CS)   cs_cnt++;
    if (DM_R) dmr_cnt++;
    if (busy) busy_cnt++;
    if (DM_W) begin
      dmw_cnt++;
      last_wr_addr = mem_addr;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rdata;

  int n_pass  = 0;
  int n_total = 0;

  logic        op_we, op_sext;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;
  int unsigned s_cs, s_dmw, s_dmr, s_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d);
    op_we = w; op_size = sz; op_sext = sx; op_addr = a; op_wdata = d;
    we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
    s_cs = cs_cnt; s_dmw = dmw_cnt; s_dmr = dmr_cnt; s_busy = busy_cnt;
  endtask

  // n0: edges already elapsed since start_op; hold: keep req high after done.
  task automatic finish_op(input int n0, input bit hold);
    int          n;
    bit          got;
    bit          fault;
    logic [31:0] off, w, v, mask, wexp;
    int unsigned idx, sh;
    int          e_lat, e_cs, e_dmw, e_dmr, e_busy;
    logic        e_err;
    off   = op_addr - BASE;
    idx   = (off / 4) % DEPTH;
    sh    = 8 * (off % 4);
    fault = (op_size == 2'd3) || (op_size == 2'd1 && (op_addr % 2) != 0) ||
            (op_size == 2'd2 && (op_addr % 4) != 0) || (op_addr < BASE) ||
            ((off / 4) >= DEPTH);
    e_err = fault; e_lat = 2; e_cs = 0; e_dmw = 0; e_dmr = 0; e_busy = 1;
    if (!fault) begin
      w = ref_mem[idx];
      if (!op_we) begin
        e_cs = 1; e_dmr = 1;
        if (op_size == 2'd0) begin
          v = (w >> sh) & 32'hFF;
          if (op_sext && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (op_size == 2'd1) begin
          v = (w >> sh) & 32'hFFFF;
          if (op_sext && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else v = w;
        ref_rdata = v;
      end else if (op_size == 2'd2) begin
        e_cs = 1; e_dmw = 1;
        ref_mem[idx] = op_wdata;
      end else begin
        e_lat = 3; e_cs = 2; e_dmw = 1; e_dmr = 1; e_busy = 2;
        mask = ((op_size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        ref_mem[idx] = (w & ~mask) | ((op_wdata << sh) & mask);
      end
    end
    n = n0; got = 1'b0;
    while (n < 8 && !got) begin
      @(posedge clk); #1;
      n++;
      got = done;
    end
    check("latency", n, e_lat);
    check("err", err, e_err);
    check("rdata", rdata, ref_rdata);
    check("cs_cycles", cs_cnt - s_cs, e_cs);
    check("dmw_cycles", dmw_cnt - s_dmw, e_dmw);
    check("dmr_cycles", dmr_cnt - s_dmr, e_dmr);
    check("busy_cycles", busy_cnt - s_busy, e_busy);
    if (e_dmw != 0) check("wr_addr", last_wr_addr, off & 32'hFFFF_FFFC);
    if (!fault) begin
      wexp = ref_mem[idx];
      check("mem_word", mem[idx[AW-1:0]], wexp);
    end
    if (!hold) begin
      req = 1'b0;
      @(posedge clk); #1;
      check("done_pulse", done, 1'b0);
    end
  endtask

  task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    start_op(w, sz, sx, a, d);
    finish_op(0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int unsigned r;
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    ref_rdata = 32'h0;
    for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_strobes", {CS, DM_W, DM_R}, 3'b000);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Preload every word through the store path
    for (int unsigned i = 0; i < DEPTH; i++) do_op(1'b1, 2'd2, 1'b0, BASE + 4 * i, $urandom);

    // Word store then load
    do_op(1'b1, 2'd2, 1'b0, A10, 32'hDEAD_BEEF);
    do_op(1'b0, 2'd2, 1'b0, A10, 32'h0);
    check("tp_word_load", rdata, 32'hDEAD_BEEF);

    // Byte RMW
    do_op(1'b1, 2'd0, 1'b0, A10 + 2, 32'h0000_0055);
    check("tp_rmw_word", mem[4], 32'hDE55_BEEF);

    // Sign extension
    do_op(1'b0, 2'd0, 1'b1, A10 + 3, 32'h0);
    check("tp_lb_sext", rdata, 32'hFFFF_FFDE);
    do_op(1'b0, 2'd0, 1'b0, A10 + 3, 32'h0);
    check("tp_lb_zext", rdata, 32'h0000_00DE);
    do_op(1'b0, 2'd1, 1'b1, A10, 32'h0);
    check("tp_lh_sext", rdata, 32'hFFFF_BEEF);

    // Faults
    do_op(1'b0, 2'd2, 1'b0, A10 + 1, 32'h0);
    do_op(1'b1, 2'd1, 1'b0, A10 + 3, 32'h1234_5678);
    do_op(1'b0, 2'd3, 1'b0, A10, 32'h0);
    do_op(1'b0, 2'd2, 1'b0, BASE + 4 * DEPTH, 32'h0);
    do_op(1'b1, 2'd2, 1'b0, BASE - 4, 32'hCAFE_F00D);
    check("tp_fault_rdata", rdata, 32'hFFFF_BEEF);

    // Back-to-back loads; an address change while busy must be ignored
    start_op(1'b0, 2'd2, 1'b0, A10, 32'h0);
    @(posedge clk); #1;
    addr = BASE + 32'h20;
    finish_op(1, 1'b1);
    start_op(1'b0, 2'd2, 1'b0, BASE + 32'h20, 32'h0);
    finish_op(0, 1'b1);
    start_op(1'b0, 2'd0, 1'b1, BASE + 32'h31, 32'h0);
    finish_op(0, 1'b0);

    // Reset during RMW_RD
    start_op(1'b1, 2'd0, 1'b0, A10 + 1, 32'h0000_00AA);
    s_dmw = dmw_cnt;
    @(posedge clk); #1;
    check("mid_busy", busy, 1'b1);
    check("mid_dmr", DM_R, 1'b1);
    reset = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_strobes", {CS, DM_W, DM_R}, 3'b000);
    check("mid_rst_done", done, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_done_after", done, 1'b0);
    check("mid_rst_no_write", dmw_cnt - s_dmw, 32'd0);
    check("mid_rst_mem", mem[4], ref_mem[4]);
    ref_rdata = 32'h0;
    check("mid_rst_rdata", rdata, ref_rdata);

    // Randomized accesses
    for (int unsigned k = 0; k < 300; k++) begin
      r  = $urandom_range(0, 19);
      if (r == 0)      a = BASE + 4 * DEPTH + $urandom_range(0, 15);
      else if (r == 1) a = BASE - 1 - $urandom_range(0, 15);
      else             a = BASE + $urandom_range(0, 4 * DEPTH - 1);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator sitting between the CPU execute stage and the word-addressed data memory.
- Translates byte, halfword and word loads/stores into memory-side CS / DM_W / DM_R / addr / wdata strobes.
- Sub-word stores are done as read-modify-write, since the memory only writes whole words.
- Performs lane extraction, sign extension, and alignment and range checking; returns a one-cycle done pulse to the CPU.

Parameters:
- DEPTH, 2048, number of 32-bit words in the attached data memory.
- BASE_ADDR, 32'h0000_0000, byte address mapped to memory word 0; must be word aligned.

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset
- req  input  1  CPU access request; sampled only while busy=0
- we  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  input  32  CPU byte address
- wdata  input  32  store data; byte in [7:0], halfword in [15:0]
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; 1 = access rejected, no memory write issued
- rdata  output  32  load result; held until the next successful load completes
- CS  output  1  memory chip select
- DM_W  output  1  memory write strobe
- DM_R  output  1  memory read strobe
- mem_addr  output  32  memory byte address = {off[31:2],2'b00}, with off = addr − BASE_ADDR
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data; combinational from CS&DM_R and mem_addr

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE; busy, done, err, CS, DM_W, DM_R = 0; rdata = 0; mem_addr and mem_wdata = 0.
  - Reset mid-operation abandons the access. No strobe is asserted after that edge, even from RMW_WR.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, FAULT.
- Strobes are a Moore decode of the state:
  - LOAD and RMW_RD: CS=1, DM_R=1.
  - STORE and RMW_WR: CS=1, DM_W=1.
  - All other states: CS, DM_R, DM_W = 0.
- IDLE with req=1: latch we, size, sign_ext, addr, wdata, then classify:
  - fault if size=11;
  - fault if halfword with addr[0]=1;
  - fault if word with addr[1:0]≠0;
  - fault if addr<BASE_ADDR or off[31:2]≥DEPTH.
  - fault → FAULT
  - load → LOAD
  - word store → STORE
  - byte/half store → RMW_RD
- req while busy=1 is ignored; the CPU holds req until done.
- Completion:
  - LOAD: rdata is captured from mem_rdata lane(s) by addr[1:0], little-endian (lane 0 = [7:0]); byte uses lane addr[1:0], halfword uses [15:0] or [31:16] by addr[1]. The result is extended per sign_ext. Next state is IDLE, with done=1, err=0.
  - STORE: mem_wdata=wdata. Next state is IDLE, with done=1.
  - RMW_RD: an internal merge register captures mem_rdata with the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Next state is RMW_WR.
  - RMW_WR: mem_wdata=merge register. Next state is IDLE, with done=1.
  - FAULT: no strobes. Next state is IDLE, with done=1, err=1; rdata is unchanged.
- done and err are registered. They are high exactly in the first IDLE cycle after completion and low otherwise.
- A new req is accepted in that same cycle (back-to-back operation).
- Latencies from the req-accept edge to done high:
  - load, word store, fault: 2 edges
  - sub-word store: 3 edges
- mem_addr and mem_wdata are stable for the whole strobe cycle. Untouched lanes of the memory word are preserved by RMW.

Test Plan:
- Word store then load: store addr=0x10 wdata=0xDEADBEEF → DM_W for exactly 1 cycle with mem_addr=0x10. Load word 0x10 → rdata=0xDEADBEEF, done after 2 edges, err=0.
- Byte RMW: with word 0x10=0xDEADBEEF, store byte addr=0x12 wdata=0x55 → DM_R cycle then DM_W cycle writing 0xDE55BEEF. busy is high for 2 cycles.
- Sign extension:
  - load byte 0x13 with sign_ext=1 → 0xFFFFFFDE
  - load byte 0x13 with sign_ext=0 → 0x000000DE
  - load half 0x10 with sign_ext=1 → 0xFFFFBEEF
- Faults, each giving done=1, err=1, no CS ever asserted, rdata unchanged:
  - word load at 0x11
  - half store at 0x13
  - size=11
  - addr=BASE_ADDR+4*DEPTH
- Back-to-back: req held high through three consecutive loads → done pulses one cycle apart from new accepts; a req raised while busy is not taken until the done cycle.
- Reset mid-RMW: reset=0 during RMW_RD → next cycle state=IDLE, DM_W never asserts, done=0, the memory word is unchanged.
